// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle ALU.
// Grants one request at a time, issues it, waits for completion or timeout, and pulses done.
module alu_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [5:0]  opc0,
  input  logic [5:0]  opc1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        alu_bgn,
  output logic [5:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic        alu_rdy,
  input  logic [15:0] alu_x,
  input  logic [15:0] alu_y,
  input  logic [3:0]  alu_flags,
  output logic [1:0]  done,
  output logic [15:0] res_x,
  output logic [15:0] res_y,
  output logic [3:0]  res_flags,
  output logic        timeout,
  output logic        busy
);

  localparam int unsigned CW  = $clog2(TIMEOUT + 1);
  localparam logic [5:0]  NOP = 6'b011111;
  localparam logic [5:0]  HLT = 6'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            gnt_q, gnt_d;
  logic            to_q, to_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [5:0]      opc_q, opc_d;
  logic [15:0]     a_q, a_d;
  logic [15:0]     b_q, b_d;
  logic [15:0]     rx_q, rx_d;
  logic [15:0]     ry_q, ry_d;
  logic [3:0]      rf_q, rf_d;

  logic            any_req;
  logic            sel;
  logic [5:0]      sel_opc;
  logic            rdy_hit;
  logic            cnt_last;

  // With both requests pending the one not served last wins.
  assign any_req  = req0 | req1;
  assign sel      = (req0 & req1) ? ~last_q : req1;
  assign sel_opc  = sel ? opc1 : opc0;
  // The first WAIT cycle (count 0) may still see the previous operation's ready.
  assign rdy_hit  = (cnt_q != '0) && alu_rdy;
  assign cnt_last = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
      opc_q   <= NOP;
      a_q     <= '0;
      b_q     <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      rf_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      rf_q    <= rf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = (sel_opc == HLT) ? S_DONE : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (rdy_hit || cnt_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    gnt_d  = gnt_q;
    to_d   = to_q;
    cnt_d  = cnt_q;
    opc_d  = opc_q;
    a_d    = a_q;
    b_d    = b_q;
    rx_d   = rx_q;
    ry_d   = ry_q;
    rf_d   = rf_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d = sel;
          opc_d = sel_opc;
          a_d   = sel ? a1 : a0;
          b_d   = sel ? b1 : b0;
          to_d  = 1'b0;
          if (sel_opc == HLT) begin
            rx_d = '0;
            ry_d = '0;
            rf_d = '0;
          end
        end
      end
      S_ISSUE: cnt_d = '0;
      S_WAIT: begin
        if (rdy_hit) begin
          rx_d = alu_x;
          ry_d = alu_y;
          rf_d = alu_flags;
          to_d = 1'b0;
        end else if (cnt_last) begin
          rx_d = '0;
          ry_d = '0;
          rf_d = '0;
          to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        last_d = gnt_q;
        opc_d  = NOP;
        a_d    = '0;
        b_d    = '0;
        cnt_d  = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_bgn    = (state_q == S_ISSUE);
    busy       = (state_q != S_IDLE);
    done       = '0;
    timeout    = 1'b0;
    if (state_q == S_DONE) begin
      done    = gnt_q ? 2'b10 : 2'b01;
      timeout = to_q;
    end
    alu_opcode = opc_q;
    alu_a      = a_q;
    alu_b      = b_q;
    res_x      = rx_q;
    res_y      = ry_q;
    res_flags  = rf_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU that answers a fixed
// number of cycles after each start strobe (x=a+b, y=a-b, flags={z,n,c,0}).
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [5:0]  opc0 = '0, opc1 = '0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        alu_bgn;
  logic [5:0]  alu_opcode;
  logic [15:0] alu_a, alu_b;
  logic        alu_rdy = 1'b0;
  logic [15:0] alu_x = '0, alu_y = '0;
  logic [3:0]  alu_flags = '0;
  logic [1:0]  done;
  logic [15:0] res_x, res_y;
  logic [3:0]  res_flags;
  logic        timeout, busy;

  int checks = 0;
  int failures = 0;
  int bgn_cnt = 0;
  int done_cnt = 0;

  int m_lat = 2;
  bit m_never = 1'b0;
  bit m_stale = 1'b0;
  int k = -1;
  logic [15:0] pa, pb;
  logic [16:0] sum;

  localparam logic [5:0] ADD = 6'd1;
  localparam logic [5:0] NOP = 6'b011111;

  alu_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .opc0(opc0), .opc1(opc1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .alu_bgn(alu_bgn), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_rdy(alu_rdy), .alu_x(alu_x), .alu_y(alu_y), .alu_flags(alu_flags),
    .done(done), .res_x(res_x), .res_y(res_y), .res_flags(res_flags),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU model; in stale mode ready and the old result stay up until the new answer.
  always @(negedge clk) begin
    if (alu_bgn === 1'b1) begin
      k  = 0;
      pa = alu_a;
      pb = alu_b;
      if (!m_stale) alu_rdy = 1'b0;
    end else if (k >= 0) begin
      k++;
      if (!m_never && k == m_lat) begin
        sum       = {1'b0, pa} + {1'b0, pb};
        alu_x     = sum[15:0];
        alu_y     = pa - pb;
        alu_flags = {sum[15:0] == 16'd0, sum[15], sum[16], 1'b0};
        alu_rdy   = 1'b1;
        k         = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (alu_bgn === 1'b1) bgn_cnt++;
    if (done !== 2'b00) done_cnt++;
  end

  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done === 2'b00 && n < max);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (alu_bgn !== 1'b0) begin failures++; $display("FAIL rst_bgn got=%b want=0", alu_bgn); end
    checks++; if (done !== 2'b00 || timeout !== 1'b0) begin failures++; $display("FAIL rst_done got=%b/%b want=00/0", done, timeout); end
    checks++; if (alu_opcode !== NOP || alu_a !== 16'd0 || alu_b !== 16'd0) begin
      failures++; $display("FAIL rst_alu got=%h/%h/%h want=1f/0000/0000", alu_opcode, alu_a, alu_b); end
    checks++; if (res_x !== 16'd0 || res_y !== 16'd0 || res_flags !== 4'd0) begin
      failures++; $display("FAIL rst_res got=%h/%h/%h want=0/0/0", res_x, res_y, res_flags); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_release_busy got=%b want=0", busy); end
  endtask

  task automatic test_single;
    int b0c;
    b0c = bgn_cnt;
    m_lat = 2; m_stale = 1'b0; m_never = 1'b0;
    opc0 = ADD; a0 = 16'd5; b0 = 16'd3; req0 = 1'b1;
    @(negedge clk);
    checks++; if (alu_bgn !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL single_issue got bgn=%b busy=%b want=1/1", alu_bgn, busy); end
    checks++; if (alu_opcode !== ADD || alu_a !== 16'd5 || alu_b !== 16'd3) begin
      failures++; $display("FAIL single_latch got=%h/%0d/%0d want=01/5/3", alu_opcode, alu_a, alu_b); end
    a0 = 16'd100;
    @(negedge clk);
    checks++; if (alu_bgn !== 1'b0 || alu_a !== 16'd5) begin failures++; $display("FAIL single_hold got bgn=%b a=%0d want=0/5", alu_bgn, alu_a); end
    @(negedge clk);
    checks++; if (done !== 2'b00) begin failures++; $display("FAIL single_early_done got=%b want=00", done); end
    @(negedge clk);
    checks++; if (done !== 2'b01 || timeout !== 1'b0) begin failures++; $display("FAIL single_done got=%b/%b want=01/0", done, timeout); end
    checks++; if (res_x !== 16'd8 || res_y !== 16'd2 || res_flags !== 4'd0) begin
      failures++; $display("FAIL single_res got=%0d/%0d/%h want=8/2/0", res_x, res_y, res_flags); end
    req0 = 1'b0; a0 = 16'd5;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || alu_opcode !== NOP || alu_a !== 16'd0 || done !== 2'b00) begin
      failures++; $display("FAIL single_idle got busy=%b opc=%h a=%0d done=%b want=0/1f/0/00", busy, alu_opcode, alu_a, done); end
    checks++; if (res_x !== 16'd8) begin failures++; $display("FAIL single_persist got=%0d want=8", res_x); end
    checks++; if (bgn_cnt - b0c !== 1) begin failures++; $display("FAIL single_bgn_count got=%0d want=1", bgn_cnt - b0c); end
  endtask

  task automatic test_round_robin;
    int n;
    logic [1:0] exp_d;
    logic [15:0] exp_x;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    opc0 = ADD; a0 = 16'd10; b0 = 16'd1;
    opc1 = ADD; a1 = 16'd20; b1 = 16'd2;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_d = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_x = (i % 2 == 0) ? 16'd11 : 16'd22;
      wait_done(30, n);
      checks++; if (done !== exp_d) begin failures++; $display("FAIL rr_order op=%0d got=%b want=%b", i, done, exp_d); end
      checks++; if (res_x !== exp_x) begin failures++; $display("FAIL rr_res op=%0d got=%0d want=%0d", i, res_x, exp_x); end
      if (i == 2) req0 = 1'b0;
      if (i == 3) req1 = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int n;
    m_never = 1'b1; m_stale = 1'b0;
    opc0 = 6'd2; a0 = 16'd1; b0 = 16'd1; req0 = 1'b1;
    wait_done(40, n);
    checks++; if (done !== 2'b01 || timeout !== 1'b1) begin failures++; $display("FAIL to_done got=%b/%b want=01/1", done, timeout); end
    checks++; if (n !== 18) begin failures++; $display("FAIL to_latency got=%0d want=18", n); end
    checks++; if (res_x !== 16'd0 || res_y !== 16'd0 || res_flags !== 4'd0) begin
      failures++; $display("FAIL to_res got=%0d/%0d/%h want=0/0/0", res_x, res_y, res_flags); end
    req0 = 1'b0;
    @(negedge clk);
    checks++; if (timeout !== 1'b0 || done !== 2'b00) begin failures++; $display("FAIL to_clear got=%b/%b want=0/00", timeout, done); end
    m_never = 1'b0;
  endtask

  task automatic test_hlt;
    int n, b0c;
    m_lat = 2;
    opc1 = ADD; a1 = 16'd20; b1 = 16'd2; req1 = 1'b1;
    wait_done(30, n);
    checks++; if (done !== 2'b10 || res_x !== 16'd22) begin failures++; $display("FAIL hlt_pre got=%b/%0d want=10/22", done, res_x); end
    req1 = 1'b0;
    @(negedge clk);
    b0c = bgn_cnt;
    opc1 = 6'd0; req1 = 1'b1;
    @(negedge clk);
    checks++; if (done !== 2'b10 || timeout !== 1'b0) begin failures++; $display("FAIL hlt_done got=%b/%b want=10/0", done, timeout); end
    checks++; if (res_x !== 16'd0 || res_y !== 16'd0 || res_flags !== 4'd0) begin
      failures++; $display("FAIL hlt_res got=%0d/%0d/%h want=0/0/0", res_x, res_y, res_flags); end
    req1 = 1'b0;
    @(negedge clk);
    checks++; if (bgn_cnt !== b0c || busy !== 1'b0) begin failures++; $display("FAIL hlt_no_bgn got bgn=%0d busy=%b want=0/0", bgn_cnt - b0c, busy); end
  endtask

  task automatic test_reset_mid;
    int n, d0c;
    m_lat = 10; m_stale = 1'b0;
    opc0 = ADD; a0 = 16'd1; b0 = 16'd2; req0 = 1'b1;
    repeat (3) @(negedge clk);
    d0c = done_cnt;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || alu_opcode !== NOP || done !== 2'b00) begin
      failures++; $display("FAIL mid_rst got busy=%b opc=%h done=%b want=0/1f/00", busy, alu_opcode, done); end
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (done_cnt !== d0c || busy !== 1'b0) begin failures++; $display("FAIL mid_no_done got pulses=%0d busy=%b want=0/0", done_cnt - d0c, busy); end
    m_lat = 2;
    a0 = 16'd7; b0 = 16'd9; req0 = 1'b1;
    wait_done(30, n);
    checks++; if (done !== 2'b01 || res_x !== 16'd16 || n !== 4) begin
      failures++; $display("FAIL mid_resume got done=%b x=%0d lat=%0d want=01/16/4", done, res_x, n); end
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stale_rdy;
    int n;
    m_lat = 2; m_stale = 1'b1;
    opc0 = ADD; a0 = 16'd100; b0 = 16'd1; req0 = 1'b1;
    wait_done(30, n);
    checks++; if (done !== 2'b01 || n !== 4) begin failures++; $display("FAIL stale_latency got done=%b lat=%0d want=01/4", done, n); end
    checks++; if (res_x !== 16'd101 || res_y !== 16'd99) begin failures++; $display("FAIL stale_res got=%0d/%0d want=101/99", res_x, res_y); end
    req0 = 1'b0;
    @(negedge clk);
    m_stale = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_timeout;
    test_hlt;
    test_reset_mid;
    test_stale_rdy;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
